game_sched: RTL and testbench
=============================

GAME_SCHED -- requirements
Module: game_sched

Interface
REQ-001 Parameter STEP_DIV, default 256: clk cycles between player-motion step strobes (>=2).
REQ-002 Parameter READY_FRAMES, default 60: frame_done pulses spent in READY before play begins.
REQ-003 Parameter SCORE_FRAMES, default 6: frame_done pulses per score increment in PLAY.
REQ-004 Parameter SCORE_MAX, default 9999: score saturation value.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  synchronous level from start key; only its rising edge is used.
REQ-008 fly  input  1  jetpack key level from player.
REQ-009 hit  input  1  level from collision logic; high while player overlaps an obstacle.
REQ-010 frame_done  input  1  one-cycle pulse per displayed frame.
REQ-011 barry_rst  output  1  one-cycle pulse that returns the player block to its start height.
REQ-012 barry_step  output  1  one-cycle pulse enabling one player-motion update.
REQ-013 fly_out  output  1  gated jetpack level to the player block.
REQ-014 scroll_en  output  1  one-cycle pulse advancing the obstacle field by one step.
REQ-015 score  output  14  current score, binary.
REQ-016 game_over  output  1  high in DEAD.
REQ-017 state  output  2  IDLE=0, READY=1, PLAY=2, DEAD=3.

Function
REQ-018 The block SHALL register start and detect its rising edge as start_rise (start high, previous sample low); no other start filtering.
REQ-019 IDLE: all pulse outputs and fly_out low; on start_rise go to READY, pulse barry_rst the next cycle, and clear score to 0.
REQ-020 READY: count frame_done pulses; on the READY_FRAMES-th pulse go to PLAY; fly_out, barry_step and scroll_en SHALL stay low.
REQ-021 PLAY: a free-running divider SHALL pulse barry_step exactly once every STEP_DIV cycles, first pulse STEP_DIV cycles after PLAY entry.
REQ-022 PLAY: fly_out SHALL equal fly delayed by one register stage; outside PLAY fly_out is 0.
REQ-023 PLAY: scroll_en SHALL pulse one cycle after each frame_done.
REQ-024 PLAY: score SHALL increment by 1 every SCORE_FRAMES frame_done pulses and saturate at SCORE_MAX (no wrap).
REQ-025 PLAY: hit high in any cycle SHALL go to DEAD next edge; the pending barry_step, scroll_en and score increment for that cycle are suppressed.
REQ-026 DEAD: game_over=1, score frozen, all pulses low; on start_rise go to READY with the same actions as REQ-019.
REQ-027 start_rise in READY or PLAY SHALL be ignored; hit outside PLAY SHALL be ignored.
REQ-028 Simultaneous hit and frame_done in PLAY: hit wins, no score or scroll update.
REQ-029 Divider and frame counters SHALL clear on every state entry; no counter may wrap silently.
REQ-030 barry_rst, barry_step and scroll_en SHALL never be high for two consecutive cycles.

Reset
REQ-031 reset low SHALL immediately (without clk) force state=IDLE, score=0, game_over=0, all pulse outputs and fly_out low, counters and start-edge register cleared.
REQ-032 reset asserted mid-PLAY or mid-DEAD SHALL abandon the game; after release the block waits in IDLE for a fresh start_rise.
REQ-033 start held high across reset release SHALL NOT produce start_rise until it falls and rises again.

Verification
REQ-034 Reset low then release, start pulse -> barry_rst one cycle, state=1, score=0; after 60 frame_done -> state=2.
REQ-035 PLAY with STEP_DIV=256 for 1024 cycles -> exactly 4 barry_step pulses, 256 cycles apart; fly toggles mirrored on fly_out one cycle later.
REQ-036 PLAY with 60 frame_done and hit low -> score=10, 60 scroll_en pulses; force score to 9999, 6 more frames -> score stays 9999.
REQ-037 hit and frame_done same cycle in PLAY -> state=3 next edge, game_over=1, score unchanged, no scroll_en; later start_rise -> state=1, score=0, barry_rst pulse.
REQ-038 reset low asynchronously mid-PLAY with score=37 -> outputs cleared before next clk edge; start held high through release -> remains IDLE until start re-rises.

Source files
------------

// File: rtl/game_sched.sv
// Game flow scheduler: IDLE -> READY -> PLAY -> DEAD, generating the player/obstacle
// timing strobes and the saturating score.
module game_sched #(
   parameter int STEP_DIV     = 256,
   parameter int READY_FRAMES = 60,
   parameter int SCORE_FRAMES = 6,
   parameter int SCORE_MAX    = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        fly,
   input  logic        hit,
   input  logic        frame_done,
   output logic        barry_rst,
   output logic        barry_step,
   output logic        fly_out,
   output logic        scroll_en,
   output logic [13:0] score,
   output logic        game_over,
   output logic [1:0]  state
);

   localparam int FRM_MAX = (READY_FRAMES > SCORE_FRAMES) ? READY_FRAMES : SCORE_FRAMES;
   localparam int FRM_W   = $clog2(FRM_MAX + 1);
   localparam int DIV_W   = $clog2(STEP_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
   localparam logic [FRM_W-1:0] RDY_LAST  = FRM_W'(READY_FRAMES - 1);
   localparam logic [FRM_W-1:0] SCR_LAST  = FRM_W'(SCORE_FRAMES - 1);
   localparam logic [13:0]      SCORE_TOP = 14'(SCORE_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READY = 2'd1,
      S_PLAY  = 2'd2,
      S_DEAD  = 2'd3
   } state_t;

   function automatic logic [13:0] sat_inc(input logic [13:0] v);
      return (v >= SCORE_TOP) ? v : v + 14'd1;
   endfunction

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [FRM_W-1:0]   frm_q, frm_d;
   logic [13:0]        score_q, score_d;
   logic               start_q;
   logic               arm_q, arm_d;
   logic               fly_q;
   logic               barry_rst_q, barry_rst_d;
   logic               barry_step_q, barry_step_d;
   logic               scroll_en_q, scroll_en_d;
   logic               start_rise;

   // arm_q only sets once start has been sampled low, so a key held through reset
   // release cannot masquerade as a fresh press.
   assign start_rise = start & ~start_q & arm_q;
   assign arm_d      = arm_q | ~start;

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      frm_d        = frm_q;
      score_d      = score_q;
      barry_rst_d  = 1'b0;
      barry_step_d = 1'b0;
      scroll_en_d  = 1'b0;

      case (state_q)
         S_IDLE, S_DEAD: begin
            if (start_rise) begin
               state_d     = S_READY;
               barry_rst_d = 1'b1;
               score_d     = '0;
               frm_d       = '0;
               div_d       = '0;
            end
         end
         S_READY: begin
            if (frame_done) begin
               if (frm_q == RDY_LAST) begin
                  state_d = S_PLAY;
                  frm_d   = '0;
                  div_d   = '0;
               end else begin
                  frm_d = frm_q + 1'b1;
               end
            end
         end
         S_PLAY: begin
            // A collision kills every update that would have happened this cycle.
            if (hit) begin
               state_d = S_DEAD;
               frm_d   = '0;
               div_d   = '0;
            end else begin
               if (div_q == DIV_LAST) begin
                  div_d        = '0;
                  barry_step_d = 1'b1;
               end else begin
                  div_d = div_q + 1'b1;
               end
               if (frame_done) begin
                  scroll_en_d = ~scroll_en_q;
                  if (frm_q == SCR_LAST) begin
                     frm_d   = '0;
                     score_d = sat_inc(score_q);
                  end else begin
                     frm_d = frm_q + 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         frm_q        <= '0;
         score_q      <= '0;
         start_q      <= 1'b0;
         arm_q        <= 1'b0;
         fly_q        <= 1'b0;
         barry_rst_q  <= 1'b0;
         barry_step_q <= 1'b0;
         scroll_en_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         frm_q        <= frm_d;
         score_q      <= score_d;
         start_q      <= start;
         arm_q        <= arm_d;
         fly_q        <= fly;
         barry_rst_q  <= barry_rst_d;
         barry_step_q <= barry_step_d;
         scroll_en_q  <= scroll_en_d;
      end
   end

   assign barry_rst  = barry_rst_q;
   assign barry_step = barry_step_q;
   assign scroll_en  = scroll_en_q;
   assign fly_out    = fly_q & (state_q == S_PLAY);
   assign score      = score_q;
   assign game_over  = (state_q == S_DEAD);
   assign state      = state_q;

endmodule

// File: tb/tb_game_sched.sv
// Bench for game_sched: segment table, hand-written corner sequences, and a
// randomized run checked against a rule-level reference model.
module tb_game_sched;

   localparam int STEP_DIV     = 256;
   localparam int READY_FRAMES = 60;
   localparam int SCORE_FRAMES = 6;
   localparam int SCORE_MAX    = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        fly = 1'b0;
   logic        hit = 1'b0;
   logic        frame_done = 1'b0;
   logic        barry_rst, barry_step, fly_out, scroll_en, game_over;
   logic [13:0] score;
   logic [1:0]  state;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt_rst, cnt_step, cnt_scroll;

   // reference model state
   bit model_on = 1'b0;
   int m_state, m_score, m_frames, m_pc;
   bit m_prev_start, m_armed, m_prev_fly;
   bit e_rst, e_step, e_scroll;

   game_sched #(
      .STEP_DIV    (STEP_DIV),
      .READY_FRAMES(READY_FRAMES),
      .SCORE_FRAMES(SCORE_FRAMES),
      .SCORE_MAX   (SCORE_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .fly       (fly),
      .hit       (hit),
      .frame_done(frame_done),
      .barry_rst (barry_rst),
      .barry_step(barry_step),
      .fly_out   (fly_out),
      .scroll_en (scroll_en),
      .score     (score),
      .game_over (game_over),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_score = 0; m_frames = 0; m_pc = 0;
      m_prev_start = 1'b0; m_armed = 1'b0; m_prev_fly = 1'b0;
      e_rst = 1'b0; e_step = 1'b0; e_scroll = 1'b0;
   endtask

   // Game rules applied to the inputs present at a clock edge.
   task automatic model_update();
      bit rise;
      rise = start && !m_prev_start && m_armed;
      e_rst = 1'b0; e_step = 1'b0; e_scroll = 1'b0;
      case (m_state)
         0, 3: if (rise) begin
            m_state = 1; m_frames = 0; m_score = 0; e_rst = 1'b1;
         end
         1: if (frame_done) begin
            m_frames++;
            if (m_frames == READY_FRAMES) begin
               m_state = 2; m_frames = 0; m_pc = 0;
            end
         end
         2: if (hit) begin
            m_state = 3;
         end else begin
            m_pc++;
            if (m_pc % STEP_DIV == 0) e_step = 1'b1;
            if (frame_done) begin
               e_scroll = 1'b1;
               m_frames++;
               if (m_frames == SCORE_FRAMES) begin
                  m_frames = 0;
                  if (m_score < SCORE_MAX) m_score++;
               end
            end
         end
         default: ;
      endcase
      m_prev_start = start;
      if (!start) m_armed = 1'b1;
      m_prev_fly = fly;
   endtask

   task automatic tick();
      @(posedge clk);
      if (model_on) model_update();
      #1;
      cnt_rst    += int'(barry_rst);
      cnt_step   += int'(barry_step);
      cnt_scroll += int'(scroll_en);
      if (model_on) begin
         check("rnd_state", state, m_state);
         check("rnd_score", score, m_score);
         check("rnd_game_over", game_over, (m_state == 3));
         check("rnd_fly_out", fly_out, (m_state == 2) ? m_prev_fly : 1'b0);
         check("rnd_barry_rst", barry_rst, e_rst);
         check("rnd_barry_step", barry_step, e_step);
         check("rnd_scroll_en", scroll_en, e_scroll);
      end
   endtask

   // nf frames spaced four cycles apart, then idle cycles.
   task automatic run_frames(input int nf, input int idle);
      for (int f = 0; f < nf; f++) begin
         repeat (3) tick();
         frame_done = 1'b1;
         tick();
         frame_done = 1'b0;
      end
      repeat (idle) tick();
   endtask

   typedef struct {
      bit st, fl, ht;
      int frames, idle;
      int e_state, e_score, e_rst, e_step, e_scroll;
   } row_t;

   row_t rows[7];
   int   step_pos[$];

   initial begin
      rows[0] = '{1, 0, 0,  0,  1, 1,  0, 1, 0,  0};
      rows[1] = '{1, 0, 0, 59,  0, 1,  0, 0, 0,  0};
      rows[2] = '{0, 0, 0,  1,  2, 2,  0, 0, 0,  0};
      rows[3] = '{1, 1, 0, 60,  2, 2, 10, 0, 0, 60};
      rows[4] = '{0, 0, 0,  0, 20, 2, 10, 0, 1,  0};
      rows[5] = '{0, 0, 1,  1,  0, 3, 10, 0, 0,  0};
      rows[6] = '{1, 0, 0,  0,  1, 1,  0, 1, 0,  0};

      // Reset state
      fly = 1'b1;
      repeat (3) tick();
      check("rst_state", state, 0);
      check("rst_score", score, 0);
      check("rst_game_over", game_over, 0);
      check("rst_fly_out", fly_out, 0);
      check("rst_pulses", {barry_rst, barry_step, scroll_en}, 0);
      reset = 1'b1;
      fly = 1'b0;
      repeat (2) tick();
      check("idle_state", state, 0);

      // Segment table
      for (int i = 0; i < 7; i++) begin
         cnt_rst = 0; cnt_step = 0; cnt_scroll = 0;
         start = rows[i].st; fly = rows[i].fl; hit = rows[i].ht;
         run_frames(rows[i].frames, rows[i].idle);
         check($sformatf("row%0d_state", i), state, rows[i].e_state);
         check($sformatf("row%0d_score", i), score, rows[i].e_score);
         check($sformatf("row%0d_game_over", i), game_over, (rows[i].e_state == 3));
         check($sformatf("row%0d_rst_cnt", i), cnt_rst, rows[i].e_rst);
         check($sformatf("row%0d_step_cnt", i), cnt_step, rows[i].e_step);
         check($sformatf("row%0d_scroll_cnt", i), cnt_scroll, rows[i].e_scroll);
      end
      hit = 1'b0; start = 1'b0; fly = 1'b0;

      // Step spacing and fly mirroring over 1024 PLAY cycles
      run_frames(READY_FRAMES, 0);
      check("play_entry", state, 2);
      for (int k = 1; k <= 1024; k++) begin
         bit f;
         f = 1'($urandom);
         fly = f;
         tick();
         check("fly_mirror", fly_out, f);
         if (barry_step === 1'b1) step_pos.push_back(k);
      end
      fly = 1'b0;
      check("step_count", step_pos.size(), 4);
      for (int j = 0; j < 4; j++)
         check("step_pos", (j < step_pos.size()) ? step_pos[j] : -1, 256 * (j + 1));

      // Hit coinciding with the frame that would bump the score
      run_frames(11, 0);
      check("pre_hit_score", score, 1);
      repeat (2) tick();
      hit = 1'b1; frame_done = 1'b1;
      tick();
      hit = 1'b0; frame_done = 1'b0;
      check("hit_state", state, 3);
      check("hit_game_over", game_over, 1);
      check("hit_score", score, 1);
      check("hit_scroll", scroll_en, 0);
      cnt_scroll = 0;
      run_frames(3, 2);
      check("dead_scroll", cnt_scroll, 0);
      check("dead_score", score, 1);
      start = 1'b1;
      tick();
      check("restart_state", state, 1);
      check("restart_score", score, 0);
      check("restart_rst", barry_rst, 1);
      start = 1'b0;
      tick();
      check("restart_rst_once", barry_rst, 0);

      // Score saturation
      run_frames(READY_FRAMES, 0);
      run_frames(SCORE_MAX * SCORE_FRAMES, 0);
      check("sat_reach", score, SCORE_MAX);
      run_frames(2 * SCORE_FRAMES, 0);
      check("sat_hold", score, SCORE_MAX);

      // Asynchronous reset mid-PLAY with start held through release
      hit = 1'b1; tick(); hit = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      run_frames(READY_FRAMES, 0);
      fly = 1'b1;
      run_frames(37 * SCORE_FRAMES, 0);
      check("pre_reset_score", score, 37);
      check("pre_reset_scroll", scroll_en, 1);
      check("pre_reset_fly_out", fly_out, 1);
      start = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("areset_state", state, 0);
      check("areset_score", score, 0);
      check("areset_fly_out", fly_out, 0);
      check("areset_pulses", {barry_rst, barry_step, scroll_en, game_over}, 0);
      repeat (2) tick();
      reset = 1'b1;
      fly = 1'b0;
      cnt_rst = 0;
      repeat (5) tick();
      check("held_start_state", state, 0);
      check("held_start_rst", cnt_rst, 0);
      start = 1'b0; tick();
      start = 1'b1; tick();
      check("rerise_state", state, 1);
      check("rerise_rst", barry_rst, 1);
      start = 1'b0;

      // Randomized run against the reference model
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      model_reset();
      model_on = 1'b1;
      for (int c = 0; c < 20000 && n_fail < 20; c++) begin
         if ($urandom_range(39, 0) == 0) start = ~start;
         fly = 1'($urandom);
         hit = ($urandom_range(799, 0) == 0);
         frame_done = !frame_done && ($urandom_range(2, 0) == 0);
         tick();
      end
      model_on = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
